register_file_32: RTL and testbench
===================================

Name: register_file_32

Overview:
- Register file directly upstream of the 32-bit ALU; drives its `a` and `b` operand buses for the single-cycle datapath.
- Two asynchronous read ports and one synchronous write port. Register 0 is hardwired to zero.
- The storage array has no per-entry reset. After reset, a clear sequencer zeroes it over 31 cycles, and `busy` holds the datapath off until the sweep completes.

Parameters:
- DATA_WIDTH, 32, width of each register and each data port.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- readReg1  in  ADDR_WIDTH  read port 1 index (rs).
- readReg2  in  ADDR_WIDTH  read port 2 index (rt).
- readData1  out  DATA_WIDTH  port 1 data, drives ALU `a`.
- readData2  out  DATA_WIDTH  port 2 data, drives ALU `b`.
- writeReg  in  ADDR_WIDTH  write index (rd/rt).
- writeData  in  DATA_WIDTH  write data (ALU result / memory data).
- regWrite  in  1  write enable.
- busy  out  1  high while the clear sweep runs; the core must stall.

Interface rule (already decided): one clock `clk`; `reset` is synchronous and active-high.

Behaviour:
- States: CLEAR, RUN.
  - Reset forces state=CLEAR and sweep pointer ptr=1.
  - busy = (state==CLEAR). busy is 1 during reset.
- CLEAR:
  - Each edge writes mem[ptr]=0, then increments ptr.
  - On the edge that writes ptr==NUM_REGS-1 (31), go to RUN. busy falls after exactly 31 edges with reset low.
  - regWrite is ignored. readData1 and readData2 are forced to 0.
- Reset asserted mid-sweep or in RUN restarts the sweep at ptr=1. Reset has priority over every write.
- RUN:
  - On an edge with regWrite=1 and writeReg!=0: mem[writeReg] <= writeData.
  - Writes to register 0 are silently dropped.
- Reads:
  - Combinational, zero latency: readDataN = (readRegN==0) ? 0 : mem[readRegN].
  - A written value appears on the reads from the cycle after the write edge.
- Same-cycle read of the register being written (no bypass): returns the old value until the edge.
- Both read ports may address the same register, including register 0; both return identical data.
- Exactly one write per cycle; there is no write-port conflict.
- ptr width is ADDR_WIDTH. ptr never wraps, because the FSM leaves CLEAR at ptr==31.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: in RUN, if regWrite=1, writeReg!=0 and writeReg==readRegN, then readDataN = writeData combinationally in the same cycle (write-through forwarding).
- Undefined: no forwarding; same-cycle reads return the stored (old) value.
- In CLEAR, outputs are 0 in both builds.

Decomposition:
- Shared package:
  - State enum {CLEAR, RUN}.
  - ZERO_REG = 0.
  - Constants DATA_WIDTH and ADDR_WIDTH.
  - NUM_REGS and LAST_REG = NUM_REGS-1.
- Sub-module rf_clear_sequencer: FSM plus ptr counter. Outputs busy, clrEn and clrAddr. The top level muxes the sequencer's write against the normal write port.

Test Plan:
- Reset for 1 cycle, then release → busy=1 for exactly 31 edges then 0; every readReg 0..31 reads 0x00000000.
- RUN, write 0xDEADBEEF to reg 5, then read readReg1=5 and readReg2=5 next cycle → both 0xDEADBEEF.
- Write 0x12345678 to reg 0 → readData1 with readReg1=0 stays 0x00000000.
- Write 0xA5A5A5A5 to reg 7 while readReg2=7 in the same cycle:
  - Without RF_WRITE_BYPASS_EN: old value 0, then 0xA5A5A5A5 next cycle.
  - With RF_WRITE_BYPASS_EN: 0xA5A5A5A5 immediately.
- Fill regs 1..31 with the value index*0x01010101, assert reset 10 cycles into the sweep → sweep restarts, busy=1 for 31 further edges, and all regs read 0 afterwards.
- During CLEAR, drive regWrite=1, writeReg=3, writeData=0xFFFFFFFF → ignored; reg 3 reads 0 after busy falls.

Source files
------------

// File: rtl/register_file_32_pkg.sv
// rtl/register_file_32_pkg.sv - shared types and constants for register_file_32
package register_file_32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam int LAST_REG   = NUM_REGS - 1;
  localparam int ZERO_REG   = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/register_file_32_clear_seq.sv
// rtl/register_file_32_clear_seq.sv - post-reset sweep that zeroes registers 1..LAST
module rf_clear_sequencer #(
  parameter int PTR_WIDTH = register_file_32_pkg::ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 busy,
  output logic                 clrEn,
  output logic [PTR_WIDTH-1:0] clrAddr
);
  import register_file_32_pkg::*;

  rf_state_t            r_state;
  logic [PTR_WIDTH-1:0] r_ptr;
  rf_state_t            w_next_state;
  logic [PTR_WIDTH-1:0] w_next_ptr;

  // State and sweep pointer; reset always restarts the sweep at register 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_ptr   <= PTR_WIDTH'(1);
    end else begin
      r_state <= w_next_state;
      r_ptr   <= w_next_ptr;
    end
  end

  // Next state and sweep outputs; the last index holds rather than wrapping.
  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    clrEn        = 1'b0;
    busy         = reset;
    clrAddr      = r_ptr;
    case (r_state)
      CLEAR: begin
        busy  = 1'b1;
        clrEn = ~reset;
        if (r_ptr == {PTR_WIDTH{1'b1}}) begin
          w_next_state = RUN;
        end else begin
          w_next_ptr = r_ptr + PTR_WIDTH'(1);
        end
      end
      RUN: begin
        w_next_state = RUN;
      end
      default: begin
        w_next_state = CLEAR;
      end
    endcase
  end

endmodule

// File: rtl/register_file_32.sv
// rtl/register_file_32.sv - 2R1W register file with zero register and post-reset clear (option RF_WRITE_BYPASS_EN)
module register_file_32 #(
  parameter int DATA_WIDTH = register_file_32_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_32_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  output logic                  busy
);
  import register_file_32_pkg::*;

  localparam int L_NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] L_ZERO = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] r_mem [L_NUM_REGS];
  logic                  w_clr_en;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_user_we;

  rf_clear_sequencer #(
    .PTR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy),
    .clrEn   (w_clr_en),
    .clrAddr (w_clr_addr)
  );

  assign w_user_we = ~busy & regWrite & (writeReg != L_ZERO);

  // Single write port shared between the clear sweep and the core; reset blocks both.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clr_en) begin
        r_mem[w_clr_addr] <= '0;
      end else if (w_user_we) begin
        r_mem[writeReg] <= writeData;
      end
    end
  end

  // Zero-latency reads; register 0 and the whole array read as zero while busy.
  always_comb begin
    readData1 = '0;
    readData2 = '0;
    if (!busy && readReg1 != L_ZERO) begin
      readData1 = r_mem[readReg1];
`ifdef RF_WRITE_BYPASS_EN
      if (w_user_we && writeReg == readReg1) begin
        readData1 = writeData;
      end
`endif
    end
    if (!busy && readReg2 != L_ZERO) begin
      readData2 = r_mem[readReg2];
`ifdef RF_WRITE_BYPASS_EN
      if (w_user_we && writeReg == readReg2) begin
        readData2 = writeData;
      end
`endif
    end
  end

endmodule

// File: tb/tb_register_file_32.sv
// tb/tb_register_file_32.sv - self-checking bench for register_file_32
module tb_register_file_32;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [31:0] readData1, readData2, writeData;
  logic        regWrite;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model [32];

  register_file_32 dut (
    .clk       (clk),
    .reset     (reset),
    .readReg1  (readReg1),
    .readReg2  (readReg2),
    .readData1 (readData1),
    .readData2 (readData2),
    .writeReg  (writeReg),
    .writeData (writeData),
    .regWrite  (regWrite),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expect_read(input logic [4:0] rr);
    if (rr == 5'd0) return 32'h0;
`ifdef RF_WRITE_BYPASS_EN
    if (regWrite && writeReg != 5'd0 && writeReg == rr) return writeData;
`endif
    return model[rr];
  endfunction

  task automatic commit_write();
    if (regWrite && writeReg != 5'd0) model[writeReg] = writeData;
  endtask

  task automatic check_all_zero(input string tag);
    regWrite = 1'b0;
    for (int r = 0; r < 32; r++) begin
      readReg1 = 5'(r);
      readReg2 = 5'(31 - r);
      #1;
      tests_run++;
      if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
        tests_failed++;
        $display("FAIL %s reg %0d: got %h/%h expected 00000000", tag, r, readData1, readData2);
      end
    end
  endtask

  // Counts edges with reset low until busy drops; optionally drives a write that must be ignored.
  task automatic sweep_and_count(input string tag, input bit drive_write);
    int cnt = 0;
    while (busy && cnt < 64) begin
      if (drive_write) begin
        regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hFFFF_FFFF;
        readReg1 = 5'd3; readReg2 = 5'($urandom_range(0, 31));
        #1;
        tests_run++;
        if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
          tests_failed++;
          $display("FAIL %s clear_read_forced: got %h/%h expected 0", tag, readData1, readData2);
        end
      end
      tick();
      cnt++;
    end
    regWrite = 1'b0;
    tests_run++;
    if (cnt !== 31) begin
      tests_failed++;
      $display("FAIL %s busy_edges: got %0d expected 31", tag, cnt);
    end
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_busy: got %b expected 1", busy);
    end
    reset = 1'b0;
    sweep_and_count("reset", 1'b0);
    check_all_zero("reset_zero");
  endtask

  task automatic test_write_read();
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hDEAD_BEEF;
    tick();
    commit_write();
    regWrite = 1'b0; readReg1 = 5'd5; readReg2 = 5'd5;
    #1;
    tests_run++;
    if (readData1 !== 32'hDEAD_BEEF || readData2 !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL write_read: got %h/%h expected deadbeef", readData1, readData2);
    end
  endtask

  task automatic test_reg0();
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234_5678;
    readReg1 = 5'd0; readReg2 = 5'd0;
    tick();
    regWrite = 1'b0;
    #1;
    tests_run++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL reg0_write: got %h/%h expected 00000000", readData1, readData2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
    exp_now = model[7];
`ifdef RF_WRITE_BYPASS_EN
    exp_now = 32'hA5A5_A5A5;
`endif
    regWrite = 1'b1; writeReg = 5'd7; writeData = 32'hA5A5_A5A5; readReg2 = 5'd7;
    #1;
    tests_run++;
    if (readData2 !== exp_now) begin
      tests_failed++;
      $display("FAIL same_cycle_read: got %h expected %h", readData2, exp_now);
    end
    tick();
    commit_write();
    regWrite = 1'b0;
    #1;
    tests_run++;
    if (readData2 !== 32'hA5A5_A5A5) begin
      tests_failed++;
      $display("FAIL next_cycle_read: got %h expected a5a5a5a5", readData2);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int i = 0; i < 300; i++) begin
      regWrite  = 1'($urandom_range(0, 1));
      writeReg  = 5'($urandom_range(0, 31));
      writeData = $urandom;
      readReg1  = 5'($urandom_range(0, 31));
      readReg2  = ($urandom_range(0, 3) == 0) ? readReg1 : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) writeReg = readReg1;
      #2;
      e1 = expect_read(readReg1);
      e2 = expect_read(readReg2);
      tests_run++;
      if (readData1 !== e1 || readData2 !== e2) begin
        tests_failed++;
        $display("FAIL random[%0d] rs=%0d rt=%0d: got %h/%h expected %h/%h",
                 i, readReg1, readReg2, readData1, readData2, e1, e2);
      end
      tick();
      commit_write();
    end
    regWrite = 1'b0;
  endtask

  task automatic test_restart_sweep();
    for (int r = 1; r < 32; r++) begin
      regWrite = 1'b1; writeReg = 5'(r); writeData = 32'(r) * 32'h0101_0101;
      tick();
      commit_write();
    end
    regWrite = 1'b0;
    readReg1 = 5'd31;
    #1;
    tests_run++;
    if (readData1 !== 32'h1F1F_1F1F) begin
      tests_failed++;
      $display("FAIL fill_reg31: got %h expected 1f1f1f1f", readData1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_sweep_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep_and_count("restart", 1'b1);
    check_all_zero("restart_zero");
  endtask

  initial begin
    reset = 1'b1; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0;
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    tick();
    test_reset();
    test_write_read();
    test_reg0();
    test_same_cycle();
    test_random();
    test_restart_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
